// File: rtl/led_frame_buffer.sv
// rtl/led_frame_buffer.sv - double-buffered LED pixel store with a valid/ready pixel stream
//
// The host fills the back bank and pulses commit. The block then swaps banks and
// streams the new front bank one pixel at a time. After the last pixel it idles
// for LATCH_CYCLES so the strip can latch, then pulses frame_done.
//
// Optional feature macro: LED_FRAME_BUFFER_BRIGHTNESS_EN
//   When it is defined, a brightness[7:0] input is added. Each colour channel c
//   is scaled to (c*(brightness+1))>>8 as the pixel is fetched.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   wr_en      write strobe into the back bank
//   wr_addr    pixel index; writes with wr_addr >= LENGTH are dropped
//   wr_data    colour 0xRRGGBB
//   commit     single-cycle pulse: the back bank holds a complete frame
//   brightness global dimming factor (only with LED_FRAME_BUFFER_BRIGHTNESS_EN)
//   px_valid   px_data holds a pixel
//   px_data    current pixel colour
//   px_ready   downstream accepts the pixel
//   frame_done one-cycle pulse at the end of the latch gap
//   busy       a frame is being fetched, streamed or latched
module led_frame_buffer #(
  parameter int LENGTH       = 2,
  parameter int ADDR_W       = 8,
  parameter int LATCH_CYCLES = 3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              commit,
`ifdef LED_FRAME_BUFFER_BRIGHTNESS_EN
  input  logic [7:0]        brightness,
`endif
  output logic              px_valid,
  output logic [23:0]       px_data,
  input  logic              px_ready,
  output logic              frame_done,
  output logic              busy
);

  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [ADDR_W:0]   LEN_EXT  = (ADDR_W + 1)'(LENGTH);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, LATCH} state_t;

  state_t           state, state_d;
  logic             front_sel, front_sel_d;
  logic             swap_pending, swap_pending_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             px_valid_d;
  logic [23:0]      px_data_d;
  logic             frame_done_d;

  logic [23:0] bank0 [LENGTH];
  logic [23:0] bank1 [LENGTH];

  logic             wr_hit;
  logic [IDX_W-1:0] wr_idx;
  logic [23:0]      front_px;
  logic [23:0]      fetch_px;

  // The range check runs on the full address so aliased indices cannot land.
  assign wr_hit = wr_en && ({1'b0, wr_addr} < LEN_EXT);
  assign wr_idx = wr_addr[IDX_W-1:0];

  // The back bank is the one front_sel does not point at.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      if (front_sel) begin
        bank0[wr_idx] <= wr_data;
      end else begin
        bank1[wr_idx] <= wr_data;
      end
    end
  end

  assign front_px = front_sel ? bank1[idx] : bank0[idx];

`ifdef LED_FRAME_BUFFER_BRIGHTNESS_EN
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
  endfunction

  assign fetch_px = {scale_ch(front_px[23:16], brightness),
                     scale_ch(front_px[15:8],  brightness),
                     scale_ch(front_px[7:0],   brightness)};
`else
  assign fetch_px = front_px;
`endif

  always_comb begin
    state_d        = state;
    front_sel_d    = front_sel;
    swap_pending_d = swap_pending || commit;
    idx_d          = idx;
    cnt_d          = cnt;
    px_valid_d     = px_valid;
    px_data_d      = px_data;
    frame_done_d   = 1'b0;
    case (state)
      IDLE: begin
        px_valid_d = 1'b0;
        if (swap_pending) begin
          front_sel_d    = ~front_sel;
          // A commit landing on the consume cycle queues the following frame.
          swap_pending_d = commit;
          idx_d          = '0;
          state_d        = FETCH;
        end
      end
      FETCH: begin
        px_data_d  = fetch_px;
        px_valid_d = 1'b1;
        state_d    = STREAM;
      end
      STREAM: begin
        if (px_valid && px_ready) begin
          px_valid_d = 1'b0;
          if (idx == LAST_IDX) begin
            cnt_d   = CNT_INIT;
            state_d = LATCH;
          end else begin
            idx_d   = idx + 1'b1;
            state_d = FETCH;
          end
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      idx          <= '0;
      cnt          <= '0;
      px_valid     <= 1'b0;
      px_data      <= '0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_d;
      front_sel    <= front_sel_d;
      swap_pending <= swap_pending_d;
      idx          <= idx_d;
      cnt          <= cnt_d;
      px_valid     <= px_valid_d;
      px_data      <= px_data_d;
      frame_done   <= frame_done_d;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_led_frame_buffer.sv
// tb/tb_led_frame_buffer.sv - randomized self-checking bench for led_frame_buffer
module tb_led_frame_buffer;

  localparam int LENGTH = 2;
  localparam int ADDR_W = 8;
  localparam int LATCH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              commit;
  logic              px_valid;
  logic [23:0]       px_data;
  logic              px_ready;
  logic              frame_done;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_frame_buffer #(
    .LENGTH      (LENGTH),
    .ADDR_W      (ADDR_W),
    .LATCH_CYCLES(LATCH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .commit    (commit),
    .px_valid  (px_valid),
    .px_data   (px_data),
    .px_ready  (px_ready),
    .frame_done(frame_done),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: two banks of pixels, which one is in front, and the
  // ordered list of pixels the stream is expected to deliver.
  logic [23:0] bank [2][LENGTH];
  int          sel = 0;
  logic [23:0] exp_q [$];
  int          n_frames = 0;

  // Monitor state
  int          ready_mode = 0;   // 0 always ready, 1 stalled, 2 random
  bit          mon_en = 1'b0;
  int          fd_count = 0;
  int          since_last = -1;
  int          since_acc = -1;
  int          px_in_frame = 0;
  bit          prev_stall = 1'b0;
  logic [23:0] prev_data = '0;

  task automatic write_px(input int addr, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = addr[ADDR_W-1:0];
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
    if (addr < LENGTH) bank[1-sel][addr] = d;
  endtask

  task automatic push_frame();
    sel = 1 - sel;
    for (int i = 0; i < LENGTH; i++) exp_q.push_back(bank[sel][i]);
    n_frames++;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    push_frame();
  endtask

  task automatic wait_valid();
    int i = 0;
    while (!px_valid && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("wait_valid", px_valid, 1'b1);
  endtask

  task automatic wait_done();
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!frame_done && i < 200);
    check("wait_done", frame_done, 1'b1);
  endtask

  // Blocks until the most recently committed frame has delivered its first pixel.
  task automatic wait_start();
    int i = 0;
    while (exp_q.size() >= LENGTH && i < 500) begin
      @(negedge clk);
      i++;
    end
    check("wait_start", exp_q.size() < LENGTH, 1'b1);
  endtask

  // Stream monitor: owns px_ready, scores accepted pixels, handshake timing,
  // hold-under-backpressure and latch-gap length.
  initial begin
    px_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        px_ready    = 1'b0;
        prev_stall  = 1'b0;
        since_last  = -1;
        since_acc   = -1;
        px_in_frame = 0;
      end else begin
        if (since_last >= 0) since_last++;
        if (frame_done) begin
          fd_count++;
          check("done_latency", since_last, LATCH + 1);
          since_last = -1;
        end else if (since_last > LATCH + 1) begin
          check("done_missing", frame_done, 1'b1);
          since_last = -1;
        end
        if (since_acc >= 0) begin
          since_acc++;
          if (since_acc == 1) begin
            check("bubble", px_valid, 1'b0);
          end else begin
            check("next_valid", px_valid, 1'b1);
            since_acc = -1;
          end
        end
        if (prev_stall) begin
          check("hold_valid", px_valid, 1'b1);
          check("hold_data", px_data, prev_data);
        end
        case (ready_mode)
          0:       px_ready = 1'b1;
          1:       px_ready = 1'b0;
          default: px_ready = ($urandom_range(3, 0) != 0);
        endcase
        if (px_valid && px_ready) begin
          if (exp_q.size() == 0) begin
            check("px_extra", px_valid, 1'b0);
          end else begin
            check("px_data", px_data, exp_q.pop_front());
          end
          px_in_frame++;
          if (px_in_frame == LENGTH) begin
            px_in_frame = 0;
            since_last  = 0;
          end else begin
            since_acc = 0;
          end
        end
        prev_stall = px_valid && !px_ready;
        prev_data  = px_data;
      end
    end
  end

  initial begin
    int          fd_snap;
    logic [23:0] d0;
    logic [23:0] d1;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    commit  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", px_valid, 1'b0);
    check("rst_data", px_data, 24'h0);
    check("rst_done", frame_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Basic frame with commit latency and inter-pixel spacing
    ready_mode = 0;
    write_px(0, 24'hFF0000);
    write_px(1, 24'h00FF00);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    push_frame();
    check("lat_c1", px_valid, 1'b0);
    @(negedge clk);
    check("lat_c2", px_valid, 1'b0);
    @(negedge clk);
    check("lat_c3", px_valid, 1'b1);
    check("first_px", px_data, 24'hFF0000);
    repeat (2) @(negedge clk);
    check("second_valid", px_valid, 1'b1);
    check("second_px", px_data, 24'h00FF00);
    wait_done();
    check("busy_at_done", busy, 1'b0);
    @(negedge clk);
    check("done_pulse", frame_done, 1'b0);
    check("busy_after", busy, 1'b0);

    // Backpressure on pixel 0
    ready_mode = 1;
    write_px(0, 24'hFF0000);
    write_px(1, 24'h00FF00);
    do_commit();
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", px_valid, 1'b1);
      check("bp_data", px_data, 24'hFF0000);
      @(negedge clk);
    end
    ready_mode = 0;
    wait_done();

    // Double buffering: rebuild the next frame while the current one streams
    ready_mode = 1;
    write_px(0, 24'hFF0000);
    write_px(1, 24'h00FF00);
    do_commit();
    wait_valid();
    write_px(0, 24'h0000FF);
    write_px(1, 24'h0000FF);
    do_commit();
    check("db_front_kept", px_data, 24'hFF0000);
    ready_mode = 0;
    wait_done();
    @(negedge clk);
    check("db_gap", px_valid, 1'b0);
    @(negedge clk);
    check("db_next_valid", px_valid, 1'b1);
    check("db_next_px", px_data, 24'h0000FF);
    wait_done();

    // Commit merging: three pulses while a frame is pending yield one frame
    fd_snap    = fd_count;
    ready_mode = 1;
    write_px(0, 24'($urandom));
    write_px(1, 24'($urandom));
    do_commit();
    wait_valid();
    write_px(0, 24'($urandom));
    write_px(1, 24'($urandom));
    commit = 1'b1;
    repeat (3) @(negedge clk);
    commit = 1'b0;
    push_frame();
    ready_mode = 0;
    wait_done();
    wait_done();
    repeat (20) @(negedge clk);
    check("merge_frames", fd_count, fd_snap + 2);
    check("merge_idle", busy, 1'b0);

    // Out-of-range write must not alias onto a real pixel
    d0 = 24'($urandom);
    d1 = 24'($urandom);
    write_px(0, d0);
    write_px(1, d1);
    write_px(5, 24'h123456);
    do_commit();
    wait_done();

    // Reset in the middle of a stalled stream
    ready_mode = 1;
    write_px(0, 24'($urandom));
    write_px(1, 24'($urandom));
    do_commit();
    wait_valid();
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", px_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", frame_done, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    n_frames--;
    sel = 0;
    fd_snap    = fd_count;
    ready_mode = 0;
    mon_en     = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_frame", fd_count, fd_snap);
    check("abort_no_busy", busy, 1'b0);

    // Randomized frames with random backpressure and overlapping rebuilds
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < LENGTH; i++) write_px(i, 24'($urandom));
      if ($urandom_range(2, 0) == 0) write_px(int'($urandom_range(255, LENGTH)), 24'($urandom));
      if ($urandom_range(1, 0) == 0) write_px(int'($urandom_range(LENGTH - 1, 0)), 24'($urandom));
      repeat ($urandom_range(2, 0)) @(negedge clk);
      do_commit();
      wait_start();
      if ($urandom_range(1, 0) == 0) wait_done();
    end
    for (int i = 0; i < 500 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("all_frames", fd_count, n_frames);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
